// File: rtl/fx3_gpif_rx_pkg.sv
// Shared definitions for the FX3 GPIF II receive path: pin-bundle bit map,
// bus widths and the per-cycle receive event decode.
package fx3_gpif_rx_pkg;

  localparam int unsigned FX3_DQ_W   = 16;
  localparam int unsigned FX3_PIN_W  = 23;

  localparam int unsigned FX3_DQ_LSB      = 0;
  localparam int unsigned FX3_DQ_MSB      = 15;
  localparam int unsigned FX3_WRN_BIT     = 16;
  localparam int unsigned FX3_RDN_BIT     = 17;
  localparam int unsigned FX3_FLB_BIT     = 18;
  localparam int unsigned FX3_PENDN_BIT   = 19;
  localparam int unsigned FX3_ADDR1_BIT   = 20;
  localparam int unsigned FX3_MEMCLK_BIT  = 21;
  localparam int unsigned FX3_MEMDO_BIT   = 22;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_CFG,
    EV_DATA,
    EV_ZLP
  } rx_evt_e;

  // A ZLP is only the falling edge of PENDn while no write strobe is active,
  // so a PENDn held low across several cycles is counted once.
  function automatic rx_evt_e rx_decode(input logic en,
                                        input logic wr_n_q,
                                        input logic pend_n_q,
                                        input logic pend_n_qq,
                                        input logic addr1_q);
    rx_evt_e ev;
    ev = EV_NONE;
    if (en) begin
      if (!wr_n_q)
        ev = addr1_q ? EV_CFG : EV_DATA;
      else if (!pend_n_q && pend_n_qq)
        ev = EV_ZLP;
    end
    return ev;
  endfunction

endpackage

// File: rtl/fx3_gpif_rx_fifo.sv
// Show-ahead synchronous FIFO; full/empty derived from an occupancy counter,
// output holds the last popped word while empty.
module fx3_sync_fifo #(
  parameter int unsigned DW    = 17,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_din,
  input  logic                     i_pop,
  output logic [DW-1:0]            o_dout,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [$clog2(DEPTH):0]   o_level_next,
  output logic                     o_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [DW-1:0] r_hold;

  logic          w_empty;
  logic          w_full;
  logic          w_rd;
  logic          w_wr;
  logic [LW-1:0] w_level_next;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_rd    = i_pop & ~w_empty;
  // When full, a push is only accepted if a pop frees the head slot this cycle.
  assign w_wr    = i_push & (~w_full | w_rd);

  always_comb begin
    w_level_next = r_level;
    unique case ({w_wr, w_rd})
      2'b10:   w_level_next = r_level + LW'(1);
      2'b01:   w_level_next = r_level - LW'(1);
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_hold   <= '0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_hold   <= r_mem[r_rd_ptr];
      end
      r_level <= w_level_next;
    end
  end

  assign o_dout       = w_empty ? r_hold : r_mem[r_rd_ptr];
  assign o_valid      = ~w_empty;
  assign o_level      = r_level;
  assign o_level_next = w_level_next;
  assign o_drop       = i_push & w_full & ~w_rd;

endmodule

// File: rtl/fx3_gpif_rx.sv
// FX3 GPIF II receive path: registered pin sampling, config/data/ZLP decode,
// packet FIFO to a valid/ready stream and the FL_A space flag back to FX3.
module fx3_gpif_rx
  import fx3_gpif_rx_pkg::*;
#(
  parameter int unsigned DW     = FX3_DQ_W,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AF_LVL = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [DW-1:0]          dq_in,
  input  logic                   wr_n,
  input  logic                   pend_n,
  input  logic                   addr1,
  output logic                   fl_a,
  output logic [DW-1:0]          m_data,
  output logic                   m_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DW-1:0]          cfg_data,
  output logic                   cfg_stb,
  output logic                   zlp_stb,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            pkt_cnt,
  output logic                   ovf_err
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FL_THR = LW'(DEPTH - AF_LVL - 1);

  logic [DW-1:0] r_dq_q;
  logic          r_wr_n_q;
  logic          r_pend_n_q;
  logic          r_pend_n_qq;
  logic          r_addr1_q;

  logic [DW-1:0] r_cfg_data;
  logic          r_cfg_stb;
  logic          r_zlp_stb;
  logic [15:0]   r_pkt_cnt;
  logic          r_ovf_err;
  logic          r_fl_a;

  rx_evt_e       w_evt;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic          w_drop;
  logic [DW:0]   w_din;
  logic [DW:0]   w_dout;
  logic [LW-1:0] w_level;
  logic [LW-1:0] w_level_next;

  always_comb begin
    w_evt = rx_decode(en, r_wr_n_q, r_pend_n_q, r_pend_n_qq, r_addr1_q);
  end

  assign w_push = (w_evt == EV_DATA);
  assign w_pop  = w_valid & m_ready;
  assign w_din  = {~r_pend_n_q, r_dq_q};

  fx3_sync_fifo #(
    .DW    (DW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_din        (w_din),
    .i_pop        (w_pop),
    .o_dout       (w_dout),
    .o_valid      (w_valid),
    .o_level      (w_level),
    .o_level_next (w_level_next),
    .o_drop       (w_drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dq_q      <= '0;
      r_wr_n_q    <= 1'b1;
      r_pend_n_q  <= 1'b1;
      r_pend_n_qq <= 1'b1;
      r_addr1_q   <= 1'b0;
      r_cfg_data  <= '0;
      r_cfg_stb   <= 1'b0;
      r_zlp_stb   <= 1'b0;
      r_pkt_cnt   <= '0;
      r_ovf_err   <= 1'b0;
      r_fl_a      <= 1'b0;
    end else begin
      r_dq_q      <= dq_in;
      r_wr_n_q    <= wr_n;
      r_pend_n_q  <= pend_n;
      r_pend_n_qq <= r_pend_n_q;
      r_addr1_q   <= addr1;

      r_cfg_stb <= (w_evt == EV_CFG);
      if (w_evt == EV_CFG)
        r_cfg_data <= r_dq_q;

      r_zlp_stb <= (w_evt == EV_ZLP);
      if ((w_evt == EV_ZLP) || ((w_evt == EV_DATA) && !r_pend_n_q))
        r_pkt_cnt <= r_pkt_cnt + 16'd1;

      if (w_drop)
        r_ovf_err <= 1'b1;

      r_fl_a <= (w_level_next <= FL_THR);
    end
  end

  assign fl_a     = r_fl_a;
  assign m_data   = w_dout[DW-1:0];
  assign m_last   = w_dout[DW];
  assign m_valid  = w_valid;
  assign cfg_data = r_cfg_data;
  assign cfg_stb  = r_cfg_stb;
  assign zlp_stb  = r_zlp_stb;
  assign level    = w_level;
  assign pkt_cnt  = r_pkt_cnt;
  assign ovf_err  = r_ovf_err;

endmodule
